// File: rtl/varredura_display.sv
// Scan controller for a multiplexed N-digit 7-segment display: one BCD nibble per slot, dead cycle between digits.
// Latency: registered outputs; carregar -> atualizado takes 1 .. N_DIGITOS*DIV_VARREDURA cycles (applied at frame boundary).
// Backpressure: none; carregar is always accepted and the last value before a boundary wins.
//
// Ports: clock/reset (async, active-high); valor + carregar load the pending buffer; piscar enables
// whole-display blinking; dados is the nibble for the decoder (4'hF = blank); anodos is the one-hot
// active-high digit enable; atualizado pulses in the boundary cycle where the pending value is applied.
// Optional: define SUPRESSAO_ZEROS_EN to blank leading zero digits (digit 0 is never blanked).
module varredura_display #(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 1000,
    parameter int DIV_PISCA     = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [4*N_DIGITOS-1:0] valor,
    input  logic                   carregar,
    input  logic                   piscar,
    output logic [3:0]             dados,
    output logic [N_DIGITOS-1:0]   anodos,
    output logic                   atualizado
);

    localparam int CW = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int PW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;
    localparam int VW = 4 * N_DIGITOS;

    localparam logic [CW-1:0] CONT_MAX  = CW'(DIV_VARREDURA - 1);
    localparam logic [IW-1:0] IND_MAX   = IW'(N_DIGITOS - 1);
    localparam logic [PW-1:0] PISCA_MAX = PW'(DIV_PISCA - 1);

    typedef enum logic {
        GAP   = 1'b0,
        ATIVO = 1'b1
    } estado_t;

    logic [CW-1:0]        contador_q, contador_d;
    logic [IW-1:0]        indice_q, indice_d;
    logic [PW-1:0]        cont_pisca_q, cont_pisca_d;
    logic                 fase_q, fase_d;
    logic [VW-1:0]        buffer_q, buffer_d;
    logic                 pendente_q, pendente_d;
    logic [VW-1:0]        exibido_q, exibido_d;
    logic [3:0]           dados_q, dados_d;
    logic [N_DIGITOS-1:0] anodos_q, anodos_d;
    logic                 atualizado_q, atualizado_d;

    estado_t              estado_d;
    logic                 fronteira_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador_q   <= '0;
            indice_q     <= '0;
            cont_pisca_q <= '0;
            fase_q       <= 1'b0;
            buffer_q     <= '0;
            pendente_q   <= 1'b0;
            exibido_q    <= '0;
            dados_q      <= 4'hF;
            anodos_q     <= '0;
            atualizado_q <= 1'b0;
        end else begin
            contador_q   <= contador_d;
            indice_q     <= indice_d;
            cont_pisca_q <= cont_pisca_d;
            fase_q       <= fase_d;
            buffer_q     <= buffer_d;
            pendente_q   <= pendente_d;
            exibido_q    <= exibido_d;
            dados_q      <= dados_d;
            anodos_q     <= anodos_d;
            atualizado_q <= atualizado_d;
        end
    end

    // Outputs are registered, so everything below is evaluated for the state
    // the scan is about to enter: the output flops then always line up with
    // contador_q/indice_q, and the boundary work lands in the boundary cycle.
    always_comb begin
        contador_d   = contador_q;
        indice_d     = indice_q;
        cont_pisca_d = cont_pisca_q;
        fase_d       = fase_q;
        buffer_d     = buffer_q;
        pendente_d   = pendente_q;
        exibido_d    = exibido_q;
        atualizado_d = 1'b0;
        dados_d      = 4'hF;
        anodos_d     = '0;
        estado_d     = GAP;
        fronteira_d  = 1'b0;

        if (contador_q == CONT_MAX) begin
            contador_d = '0;
            indice_d   = (indice_q == IND_MAX) ? '0 : indice_q + 1'b1;
        end else begin
            contador_d = contador_q + 1'b1;
        end

        estado_d    = (contador_d == '0) ? GAP : ATIVO;
        fronteira_d = (estado_d == GAP) && (indice_d == '0);

        if (carregar) begin
            buffer_d   = valor;
            pendente_d = 1'b1;
        end

        if (fronteira_d) begin
            if (cont_pisca_q == PISCA_MAX) begin
                cont_pisca_d = '0;
                fase_d       = ~fase_q;
            end else begin
                cont_pisca_d = cont_pisca_q + 1'b1;
            end
            // A strobe in the cycle just before the boundary is applied here
            // directly, giving the one-cycle minimum latency. A strobe during
            // the boundary cycle itself arrives after this transfer and waits.
            if (pendente_q || carregar) begin
                exibido_d    = carregar ? valor : buffer_q;
                pendente_d   = 1'b0;
                atualizado_d = 1'b1;
            end
        end

        if (estado_d == ATIVO) begin
            dados_d = exibido_d[4*indice_d +: 4];
            for (int i = 0; i < N_DIGITOS; i++) begin
                anodos_d[i] = (indice_d == IW'(i));
            end
            // Blink hides the digit but keeps dados scanning.
            if (piscar && fase_d) begin
                anodos_d = '0;
            end
`ifdef SUPRESSAO_ZEROS_EN
            // Digit i is a leading zero when it and every digit above it are 0.
            if ((indice_d != '0) && ((exibido_d >> (4*indice_d)) == '0)) begin
                dados_d  = 4'hF;
                anodos_d = '0;
            end
`endif
        end
    end

    assign dados      = dados_q;
    assign anodos     = anodos_q;
    assign atualizado = atualizado_q;

endmodule

// File: tb/tb_varredura_display.sv
module tb_varredura_display;

    logic        clock;
    logic        reset;
    logic [15:0] valor;
    logic        carregar;
    logic        piscar;
    logic [3:0]  dados;
    logic [3:0]  anodos;
    logic        atualizado;

    int tests;
    int fails;
    int frame_no;

    varredura_display #(
        .N_DIGITOS    (4),
        .DIV_VARREDURA(4),
        .DIV_PISCA    (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .valor     (valor),
        .carregar  (carregar),
        .piscar    (piscar),
        .dados     (dados),
        .anodos    (anodos),
        .atualizado(atualizado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walks one whole frame starting in its boundary cycle and ending in the
    // next boundary cycle. w is the word expected on screen; upd says whether
    // atualizado is expected in the boundary cycle. Up to two load strobes can
    // be placed at chosen cycles of the frame (-1 = none).
    task automatic run_frame(input logic [15:0] w, input bit upd,
                             input int la1, input logic [15:0] v1,
                             input int la2, input logic [15:0] v2);
        for (int j = 0; j < 16; j++) begin
            int s;
            int c;
            logic [3:0] ed;
            logic [3:0] ea;
            s = j / 4;
            c = j % 4;
            if (c == 0) begin
                ed = 4'hF;
                ea = 4'b0000;
            end else begin
                ed = w[4*s +: 4];
                ea = 4'b0001 << s;
                if (piscar && (frame_no % 2 == 1)) ea = 4'b0000;
`ifdef SUPRESSAO_ZEROS_EN
                if ((s > 0) && ((w >> (4*s)) == 16'h0)) begin
                    ed = 4'hF;
                    ea = 4'b0000;
                end
`endif
            end
            chk($sformatf("f%0d c%0d anodos", frame_no, j), {12'h0, anodos}, {12'h0, ea});
            chk($sformatf("f%0d c%0d dados", frame_no, j), {12'h0, dados}, {12'h0, ed});
            chk($sformatf("f%0d c%0d atualizado", frame_no, j), {15'h0, atualizado},
                {15'h0, (j == 0) && upd});
            carregar = 1'b0;
            if (j == la1) begin
                carregar = 1'b1;
                valor    = v1;
            end
            if (j == la2) begin
                carregar = 1'b1;
                valor    = v2;
            end
            tick();
        end
        carregar = 1'b0;
        frame_no++;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        frame_no = 0;
        reset    = 1'b1;
        valor    = 16'h0;
        carregar = 1'b0;
        piscar   = 1'b0;

        tick();
        tick();
        chk("reset anodos", {12'h0, anodos}, 16'h0000);
        chk("reset dados", {12'h0, dados}, 16'h000F);
        chk("reset atualizado", {15'h0, atualizado}, 16'h0000);
        reset = 1'b0;

        // Load in the very first (boundary) cycle: waits a full frame.
        run_frame(16'h0000, 1'b0, 0, 16'h1234, -1, 16'h0);
        // Scan order over two frames.
        run_frame(16'h1234, 1'b1, -1, 16'h0, -1, 16'h0);
        run_frame(16'h1234, 1'b0, 8, 16'h5678, -1, 16'h0);
        // Mid-frame load shows only after the boundary; then overwrite twice.
        run_frame(16'h5678, 1'b1, 2, 16'h1111, 10, 16'h2222);
        // Single pulse for the overwrite; load exactly in the boundary cycle.
        run_frame(16'h2222, 1'b1, 0, 16'h9999, -1, 16'h0);
        // Boundary-cycle load applied 16 cycles later; strobe one cycle before
        // the boundary gives the minimum latency, with nibbles above 9.
        run_frame(16'h9999, 1'b1, 15, 16'h00AB, -1, 16'h0);
        run_frame(16'h00AB, 1'b1, -1, 16'h0, -1, 16'h0);

        // Blink: phase toggles every frame with DIV_PISCA=1 (odd frames dark).
        piscar = 1'b1;
        run_frame(16'h00AB, 1'b0, -1, 16'h0, -1, 16'h0);
        run_frame(16'h00AB, 1'b0, -1, 16'h0, -1, 16'h0);
        piscar = 1'b0;
        run_frame(16'h00AB, 1'b0, -1, 16'h0, -1, 16'h0);

        // Reset during the digit-2 slot with a load still pending.
        carregar = 1'b1;
        valor    = 16'h7777;
        tick();
        carregar = 1'b0;
        for (int k = 0; k < 8; k++) tick();
`ifdef SUPRESSAO_ZEROS_EN
        chk("pre-reset anodos", {12'h0, anodos}, 16'h0000);
        chk("pre-reset dados", {12'h0, dados}, 16'h000F);
`else
        chk("pre-reset anodos", {12'h0, anodos}, 16'h0004);
        chk("pre-reset dados", {12'h0, dados}, 16'h0000);
`endif
        reset = 1'b1;
        #1;
        chk("async reset anodos", {12'h0, anodos}, 16'h0000);
        chk("async reset dados", {12'h0, dados}, 16'h000F);
        chk("async reset atualizado", {15'h0, atualizado}, 16'h0000);
        tick();
        reset    = 1'b0;
        frame_no = 0;

        // Pending 7777 was discarded; display restarts at 0000.
        run_frame(16'h0000, 1'b0, 15, 16'h0042, -1, 16'h0);
        run_frame(16'h0042, 1'b1, 15, 16'h0000, -1, 16'h0);
        run_frame(16'h0000, 1'b1, -1, 16'h0, -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
